upcount_ctrl: RTL and testbench

UPCOUNT_CTRL -- requirements
Module: upcount_ctrl

---
 rtl/upcount_pkg.sv | 12 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/upcount_ctrl.sv | 75 +++++++
 tb/tb_upcount_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upcount_pkg.sv
// upcount_pkg: shared state encoding and counter limit for the up-counter control slice
package upcount_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int unsigned CNT_MAX = 9999;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button, debounces its level and emits a one-cycle press pulse
module btn_debounce
    import upcount_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          flip;

    // Count consecutive cycles where the synchronized input disagrees with the accepted level
    always_comb begin
        sync_d  = {sync_q[0], i_btn};
        flip    = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYC - 1));
        cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
        level_d = flip ? sync_q[1] : level_q;
        press_d = flip & sync_q[1];
    end

    // Synchronizer, debounce counter, accepted level and press pulse registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: rtl/upcount_ctrl.sv
// upcount_ctrl: run/stop/clear FSM and tick divider driving a 0..9999 up-counter
module upcount_ctrl
    import upcount_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 10,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    output logic       o_tick,
    output logic       o_clear,
    output logic       o_run,
    output logic [1:0] o_state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("upcount_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          run_press, clr_press, tick;
    logic          unused_run_level, unused_clr_level;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_btn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_run_stop),
        .o_level (unused_run_level),
        .o_press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_btn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_clear),
        .o_level (unused_clr_level),
        .o_press (clr_press)
    );

    // Next state from press pulses; clear wins over run in STOP, divider advances only in RUN
    always_comb begin
        tick = (state_q == ST_RUN) && (div_q == DW'(DIV - 1));
        case (state_q)
            ST_STOP: state_d = clr_press ? ST_CLEAR : run_press ? ST_RUN : ST_STOP;
            ST_RUN:  state_d = run_press ? ST_STOP : ST_RUN;
            default: state_d = ST_STOP;
        endcase
        div_d = (state_q == ST_RUN) ? (tick ? '0 : div_q + 1'b1) :
                (state_q == ST_CLEAR) ? '0 : div_q;
    end

    // State and divider registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_STOP;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    assign o_tick  = tick;
    assign o_clear = (state_q == ST_CLEAR);
    assign o_run   = (state_q == ST_RUN);
    assign o_state = state_q;

endmodule

// File: tb/tb_upcount_ctrl.sv
// tb_upcount_ctrl: scenario tasks plus randomized buttons checked against a window-based model
module tb_upcount_ctrl;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DB      = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_clr = 1'b0;
    logic       o_tick, o_clear, o_run;
    logic [1:0] o_state;

    int n_vec = 0;
    int n_err = 0;

    // Model: raw samples per edge, accepted levels, press pulses, state and RUN-cycle phase
    bit rq[$];
    bit cq[$];
    bit m_rl, m_cl, m_rp, m_cp;
    int m_state, m_phase;

    upcount_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYC(DB)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_btn_run_stop (btn_run),
        .i_btn_clear    (btn_clr),
        .o_tick         (o_tick),
        .o_clear        (o_clear),
        .o_run          (o_run),
        .o_state        (o_state)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic model_reset();
        rq.delete();
        cq.delete();
        for (int i = 0; i < DB + 2; i++) begin
            rq.push_front(1'b0);
            cq.push_front(1'b0);
        end
        m_rl = 0; m_cl = 0; m_rp = 0; m_cp = 0;
        m_state = 0; m_phase = 0;
    endtask

    // A level is accepted once the DB synchronized samples (two edges old) all disagree with it
    task automatic model_edge();
        bit rf, cf;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_state == 1) m_phase = (m_phase + 1) % DIV;
        else if (m_state == 2) m_phase = 0;
        m_state = (m_state == 0) ? (m_cp ? 2 : m_rp ? 1 : 0) :
                  (m_state == 1) ? (m_rp ? 0 : 1) : 0;
        rq.push_front(btn_run);
        cq.push_front(btn_clr);
        void'(rq.pop_back());
        void'(cq.pop_back());
        rf = 1; cf = 1;
        for (int i = 2; i < DB + 2; i++) begin
            if (rq[i] == m_rl) rf = 0;
            if (cq[i] == m_cl) cf = 0;
        end
        m_rp = rf && !m_rl;
        m_cp = cf && !m_cl;
        if (rf) m_rl = !m_rl;
        if (cf) m_cl = !m_cl;
    endtask

    function automatic logic [4:0] m_out();
        return {(m_state == 1 && m_phase == DIV - 1), (m_state == 2), (m_state == 1), 2'(m_state)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic press_settle(input bit r, input bit c, input int hold);
        btn_run = r;
        btn_clr = c;
        repeat (hold) step();
        btn_run = 0;
        btn_clr = 0;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst = 1;
        model_reset();
        #2;
        n_vec++;
        if ({o_tick, o_clear, o_run, o_state} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_immediate: got %b expected %b", {o_tick, o_clear, o_run, o_state}, 5'b0);
        end
        step();
        step();
        rst = 0;
        step();
        n_vec++;
        if ({o_tick, o_clear, o_run, o_state} !== m_out()) begin
            n_err++;
            $display("FAIL reset_release: got %b expected %b", {o_tick, o_clear, o_run, o_state}, m_out());
        end
    endtask

    task automatic test_run_ticks();
        int entry = 0, first = 0, nt = 0;
        btn_run = 1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 10) btn_run = 0;
            if (o_run && entry == 0) entry = i;
            if (o_tick) begin
                if (first == 0) first = i;
                if (entry != 0 && i < entry + 50) nt++;
            end
            n_vec++;
            if ({o_tick, o_clear, o_run, o_state} !== m_out()) begin
                n_err++;
                $display("FAIL run_model cyc %0d: got %b expected %b", i, {o_tick, o_clear, o_run, o_state}, m_out());
            end
        end
        n_vec++;
        if (entry != 7) begin n_err++; $display("FAIL run_entry: got cycle %0d expected 7", entry); end
        n_vec++;
        if (first != 16) begin n_err++; $display("FAIL first_tick: got cycle %0d expected 16", first); end
        n_vec++;
        if (nt != 5) begin n_err++; $display("FAIL tick_count_50: got %0d expected 5", nt); end
        press_settle(1, 0, 4);
        n_vec++;
        if (o_state !== 2'd0) begin n_err++; $display("FAIL stop_after_run: got %0d expected 0", o_state); end
    endtask

    task automatic test_glitch();
        btn_run = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 3) btn_run = 0;
            n_vec++;
            if ({o_tick, o_run, o_state} !== 4'b0) begin
                n_err++;
                $display("FAIL glitch cyc %0d: got %b expected %b", i, {o_tick, o_run, o_state}, 4'b0);
            end
        end
    endtask

    task automatic test_clear();
        int at = 0, nclr = 0, entry = 0, tk = 0;
        btn_clr = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 4) btn_clr = 0;
            if (o_clear) begin
                nclr++;
                if (at == 0) at = i;
                n_vec++;
                if (o_state !== 2'd2) begin n_err++; $display("FAIL clear_state: got %0d expected 2", o_state); end
            end
        end
        n_vec++;
        if (at != 7 || nclr != 1) begin
            n_err++;
            $display("FAIL clear_pulse: got at %0d count %0d expected at 7 count 1", at, nclr);
        end
        n_vec++;
        if (o_state !== 2'd0) begin n_err++; $display("FAIL clear_to_stop: got %0d expected 0", o_state); end
        btn_run = 1;
        for (int i = 1; i <= 20 && entry == 0; i++) begin
            step();
            if (i == 4) btn_run = 0;
            if (o_run) entry = i;
        end
        btn_run = 0;
        for (int j = 1; j <= 12 && tk == 0; j++) begin
            step();
            if (o_tick) tk = j;
        end
        n_vec++;
        if (tk != 9) begin n_err++; $display("FAIL clear_zeroes_div: got tick after %0d expected 9", tk); end
        btn_clr = 1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 4) btn_clr = 0;
            n_vec++;
            if ({o_clear, o_run} !== 2'b01) begin
                n_err++;
                $display("FAIL clear_in_run cyc %0d: got %b expected 01", i, {o_clear, o_run});
            end
        end
        press_settle(1, 0, 4);
    endtask

    task automatic test_resume();
        int entry = 0, leave = 0, tk = 0;
        press_settle(0, 1, 4);
        btn_run = 1;
        for (int i = 1; i <= 20 && entry == 0; i++) begin
            step();
            if (i == 4) btn_run = 0;
            if (o_run) entry = i;
        end
        btn_run = 0;
        for (int j = 1; j <= 30 && leave == 0; j++) begin
            step();
            if (j == 9) btn_run = 1;
            if (j == 13) btn_run = 0;
            if (!o_run) leave = j;
        end
        n_vec++;
        if (leave != 16) begin n_err++; $display("FAIL stop_timing: got %0d expected 16", leave); end
        repeat (10) step();
        entry = 0;
        btn_run = 1;
        for (int i = 1; i <= 20 && entry == 0; i++) begin
            step();
            if (i == 4) btn_run = 0;
            if (o_run) entry = i;
        end
        btn_run = 0;
        for (int j = 1; j <= 12 && tk == 0; j++) begin
            step();
            if (o_tick) tk = j;
        end
        n_vec++;
        if (tk != 3) begin n_err++; $display("FAIL resume_phase: got tick after %0d expected 3", tk); end
        press_settle(1, 0, 4);
    endtask

    task automatic test_both();
        int at = 0, nclr = 0;
        bit run_seen = 0;
        btn_run = 1;
        btn_clr = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 4) begin btn_run = 0; btn_clr = 0; end
            if (o_run) run_seen = 1;
            if (o_clear) begin nclr++; if (at == 0) at = i; end
        end
        n_vec++;
        if (run_seen || nclr != 1 || at != 7) begin
            n_err++;
            $display("FAIL both_pressed: got run %0d clears %0d at %0d expected run 0 clears 1 at 7", run_seen, nclr, at);
        end
        n_vec++;
        if (o_state !== 2'd0) begin n_err++; $display("FAIL both_to_stop: got %0d expected 0", o_state); end
    endtask

    task automatic test_reset_mid_run();
        int entry = 0, tk = 0;
        press_settle(0, 1, 4);
        btn_run = 1;
        for (int i = 1; i <= 20 && entry == 0; i++) begin
            step();
            if (i == 4) btn_run = 0;
            if (o_run) entry = i;
        end
        btn_run = 0;
        repeat (4) step();
        #2;
        rst = 1;
        model_reset();
        #1;
        n_vec++;
        if ({o_tick, o_clear, o_run, o_state} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_mid_run: got %b expected %b", {o_tick, o_clear, o_run, o_state}, 5'b0);
        end
        step();
        rst = 0;
        entry = 0;
        btn_run = 1;
        for (int i = 1; i <= 20 && entry == 0; i++) begin
            step();
            if (i == 4) btn_run = 0;
            if (o_run) entry = i;
        end
        btn_run = 0;
        n_vec++;
        if (entry != 7) begin n_err++; $display("FAIL run_after_reset: got entry %0d expected 7", entry); end
        for (int j = 1; j <= 12 && tk == 0; j++) begin
            step();
            if (o_tick) tk = j;
        end
        n_vec++;
        if (tk != 9) begin n_err++; $display("FAIL tick_after_reset: got tick after %0d expected 9", tk); end
        press_settle(1, 0, 4);
    endtask

    task automatic test_held_reset();
        int at = 0;
        btn_clr = 1;
        rst = 1;
        model_reset();
        step();
        step();
        rst = 0;
        for (int i = 1; i <= 20 && at == 0; i++) begin
            step();
            if (o_clear) at = i;
        end
        n_vec++;
        if (at != 7) begin n_err++; $display("FAIL held_through_reset: got clear at %0d expected 7", at); end
        btn_clr = 0;
        repeat (12) step();
    endtask

    task automatic test_random();
        rst = 1;
        model_reset();
        step();
        rst = 0;
        for (int i = 1; i <= 1500; i++) begin
            if ($urandom_range(0, 5) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 6) == 0) btn_clr = ~btn_clr;
            rst = (i == 700);
            step();
            n_vec++;
            if ({o_tick, o_clear, o_run, o_state} !== m_out()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b expected %b", i, {o_tick, o_clear, o_run, o_state}, m_out());
            end
        end
        rst = 0;
        btn_run = 0;
        btn_clr = 0;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_run_ticks();
        test_glitch();
        test_clear();
        test_resume();
        test_both();
        test_reset_mid_run();
        test_held_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
